// File: rtl/id_hazard_sched.sv
// Decode-stage issue scheduler: per-register in-flight write scoreboard, RAW/full stalls, HALT drain and dump pulse.
// Optional macro WB_BYPASS_EN: a source retiring at writeback this cycle (last pending write) does not stall.
module id_hazard_sched #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic                id_rs_used,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                id_rt_used,
  input  logic                id_wr_en,
  input  logic [REG_W-1:0]    id_wr_reg,
  input  logic                id_dump,
  input  logic                wb_wr_en,
  input  logic [REG_W-1:0]    wb_wr_reg,
  output logic                stall,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                dump_out,
  output logic                err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt     [NUM_REGS];
  logic [CNT_W-1:0]     cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]  pend_vec;
  logic [NUM_REGS-1:0]  inc_vec;
  logic [NUM_REGS-1:0]  dec_vec;
  logic                 hazard;
  logic                 wr_full;
  logic                 all_zero_nxt;
  logic                 err_nxt;
  logic                 dump_nxt;

  // Pending-write view of each register as seen by a reader in decode
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_vec[r] = (cnt[r] != '0);
`ifdef WB_BYPASS_EN
      if (wb_wr_en && (wb_wr_reg == REG_W'(r)) && (cnt[r] == CNT_ONE))
        pend_vec[r] = 1'b0;
`endif
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      busy_mask[r] = (cnt[r] != '0);
  end

  // A full counter blocks another write to that register rather than wrapping
  assign wr_full = (cnt[id_wr_reg] == CNT_MAX);
  assign hazard  = (id_rs_used & pend_vec[id_rs])
                 | (id_rt_used & pend_vec[id_rt])
                 | (id_wr_en & wr_full);
  assign stall   = (state != ST_RUN) | (id_valid & hazard);
  assign issue   = id_valid & ~stall;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = issue & id_wr_en & (id_wr_reg == REG_W'(r));
      dec_vec[r] = wb_wr_en & (wb_wr_reg == REG_W'(r));
    end
  end

  // Next scoreboard state; retiring an idle register flags err and holds at zero
  always_comb begin
    err_nxt      = err;
    all_zero_nxt = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r] = cnt[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_nxt[r] = cnt[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt[r] == '0)
          err_nxt = 1'b1;
        else
          cnt_nxt[r] = cnt[r] - CNT_ONE;
      end
      if (cnt_nxt[r] != '0)
        all_zero_nxt = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    dump_nxt  = 1'b0;
    case (state)
      ST_RUN: begin
        if (issue && id_dump)
          state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (all_zero_nxt) begin
          state_nxt = ST_HALT;
          dump_nxt  = 1'b1;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      dump_out <= 1'b0;
      err      <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
    end else begin
      state    <= state_nxt;
      dump_out <= dump_nxt;
      err      <= err_nxt;
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= cnt_nxt[r];
    end
  end

endmodule

// File: tb/tb_id_hazard_sched.sv
// Directed table-driven bench for id_hazard_sched, plus hand sequences for reset and halt corners.
module tb_id_hazard_sched;

`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_rs_used, id_rt_used, id_wr_en, id_dump, wb_wr_en;
  logic [2:0] id_rs, id_rt, id_wr_reg, wb_wr_reg;
  logic       stall, issue, dump_out, err;
  logic [7:0] busy_mask;

  int checks = 0;
  int errors = 0;

  id_hazard_sched #(.NUM_REGS(8), .REG_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_dump(id_dump),
    .wb_wr_en(wb_wr_en), .wb_wr_reg(wb_wr_reg),
    .stall(stall), .issue(issue), .busy_mask(busy_mask),
    .dump_out(dump_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] rs;
    logic       rsu;
    logic [2:0] rt;
    logic       rtu;
    logic       we;
    logic [2:0] wr;
    logic       dmp;
    logic       wbe;
    logic [2:0] wbr;
    logic       x_stall;
    logic       x_issue;
    logic [7:0] x_busy;
    logic       x_dump;
    logic       x_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [2:0] rs, logic rsu, logic [2:0] rt, logic rtu,
                              logic we, logic [2:0] wr, logic dmp, logic wbe, logic [2:0] wbr,
                              logic s, logic i, logic [7:0] b, logic d, logic e);
    vec_t t;
    t.v = v; t.rs = rs; t.rsu = rsu; t.rt = rt; t.rtu = rtu;
    t.we = we; t.wr = wr; t.dmp = dmp; t.wbe = wbe; t.wbr = wbr;
    t.x_stall = s; t.x_issue = i; t.x_busy = b; t.x_dump = d; t.x_err = e;
    return t;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    id_valid = t.v; id_rs = t.rs; id_rs_used = t.rsu; id_rt = t.rt; id_rt_used = t.rtu;
    id_wr_en = t.we; id_wr_reg = t.wr; id_dump = t.dmp; wb_wr_en = t.wbe; wb_wr_reg = t.wbr;
  endtask

  task automatic step(vec_t t, string tag);
    @(negedge clk);
    drive(t);
    #1;
    chk({tag, ".stall"}, {7'd0, stall}, {7'd0, t.x_stall});
    chk({tag, ".issue"}, {7'd0, issue}, {7'd0, t.x_issue});
    chk({tag, ".busy"}, busy_mask, t.x_busy);
    chk({tag, ".dump"}, {7'd0, dump_out}, {7'd0, t.x_dump});
    chk({tag, ".err"}, {7'd0, err}, {7'd0, t.x_err});
  endtask

  task automatic rand_inputs();
    id_valid = 1'($urandom); id_rs = 3'($urandom); id_rs_used = 1'($urandom);
    id_rt = 3'($urandom); id_rt_used = 1'($urandom); id_wr_en = 1'($urandom);
    id_wr_reg = 3'($urandom); id_dump = 1'($urandom); wb_wr_en = 1'($urandom);
    wb_wr_reg = 3'($urandom);
  endtask

  task automatic reset_check(string tag);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      #1;
      chk({tag, ".busy"}, busy_mask, 8'h00);
      chk({tag, ".dump"}, {7'd0, dump_out}, 8'h00);
      chk({tag, ".err"}, {7'd0, err}, 8'h00);
      @(negedge clk);
    end
    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,0,0));
    #1;
    chk({tag, ".stall"}, {7'd0, stall}, 8'h00);
    chk({tag, ".issue"}, {7'd0, issue}, 8'h00);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,0,0));

    // v   rs rsu rt rtu we wr dmp wbe wbr | stall issue busy dump err
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,3,0,0,0, 0,1,8'h00,0,0));
    vecs.push_back(mk(1,3,1,0,0,0,0,0,0,0, 1,0,8'h08,0,0));
    vecs.push_back(mk(1,3,1,0,0,0,0,0,1,3, !BYP,BYP,8'h08,0,0));
    vecs.push_back(mk(1,3,1,0,0,0,0,0,0,0, 0,1,8'h00,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,1,0,0,0, 0,1,8'h00,0,0));
    vecs.push_back(mk(1,1,0,1,1,0,0,0,0,0, 1,0,8'h02,0,0));
    vecs.push_back(mk(1,1,0,0,1,0,0,0,0,0, 0,1,8'h02,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,1, 0,0,8'h02,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,5,0,0,0, 0,1,8'h00,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,5,0,0,0, 0,1,8'h20,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,5,0,0,0, 0,1,8'h20,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,5,0,0,0, 1,0,8'h20,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,5,0,1,5, 1,0,8'h20,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,5,0,0,0, 0,1,8'h20,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,5, 0,0,8'h20,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,5, 0,0,8'h20,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,5, 0,0,8'h20,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,2,0,0,0, 0,1,8'h00,0,0));
    vecs.push_back(mk(1,0,0,0,0,1,2,0,1,2, 0,1,8'h04,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,2, 0,0,8'h04,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,7, 0,0,8'h00,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,0,1));
    vecs.push_back(mk(1,0,0,0,0,1,7,0,0,0, 0,1,8'h00,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,1,7, 0,0,8'h80,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,0,1));
    vecs.push_back(mk(1,0,0,0,0,1,4,0,0,0, 0,1,8'h00,0,1));
    vecs.push_back(mk(1,0,0,0,0,1,6,0,0,0, 0,1,8'h10,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,1,0,0, 0,1,8'h50,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 1,0,8'h50,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,4, 1,0,8'h50,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,1,6, 1,0,8'h40,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 1,0,8'h00,1,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0, 1,0,8'h00,0,1));
    vecs.push_back(mk(1,0,0,0,0,1,3,0,0,0, 1,0,8'h00,0,1));

    reset_check("rst0");

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

    // Reset out of HALT, then a plain instruction must issue again
    reset_check("rst_halt");
    step(mk(1,0,0,0,0,0,0,0,0,0, 0,1,8'h00,0,0), "post_halt");

    // Dump with an empty scoreboard: one DRAIN cycle, then a single pulse
    step(mk(1,0,0,0,0,0,0,1,0,0, 0,1,8'h00,0,0), "e_dump");
    step(mk(1,0,0,0,0,0,0,0,0,0, 1,0,8'h00,0,0), "e_drain");
    step(mk(1,0,0,0,0,0,0,0,0,0, 1,0,8'h00,1,0), "e_pulse");
    step(mk(1,0,0,0,0,0,0,0,0,0, 1,0,8'h00,0,0), "e_after");

    // Reset in the middle of DRAIN: no pulse, scoreboard cleared
    reset_check("rst_pre");
    step(mk(1,0,0,0,0,1,0,0,0,0, 0,1,8'h00,0,0), "d_wr0");
    step(mk(1,0,0,0,0,0,0,1,0,0, 0,1,8'h01,0,0), "d_dump");
    step(mk(1,0,0,0,0,0,0,0,0,0, 1,0,8'h01,0,0), "d_drain");
    reset_check("rst_drain");
    step(mk(0,0,0,0,0,0,0,0,0,0, 0,0,8'h00,0,0), "d_post0");
    step(mk(1,0,1,0,0,0,0,0,0,0, 0,1,8'h00,0,0), "d_post1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
